// File: rtl/seven_seg_monitor.sv
// Passive readback monitor for the multiplexed seven-segment bus: re-derives the
// BCD digit in each position, publishes whole frames atomically and flags errors.
module seven_seg_monitor #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] AN,
   input  logic       CA,
   input  logic       CB,
   input  logic       CC,
   input  logic       CD,
   input  logic       CE,
   input  logic       CF,
   input  logic       CG,
   input  logic       CLR_ERR,
   output logic [3:0] D0,
   output logic [3:0] D1,
   output logic [3:0] D2,
   output logic [3:0] D3,
   output logic       FRAME_DONE,
   output logic       ERR,
   output logic [7:0] ERR_CNT
);

   localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

   function automatic logic is_slot(input logic [3:0] an);
      return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
   endfunction

   function automatic logic [3:0] decode(input logic [6:0] seg);
      logic [3:0] code;
      case (seg)
         7'h01:   code = 4'd0;
         7'h4F:   code = 4'd1;
         7'h12:   code = 4'd2;
         7'h06:   code = 4'd3;
         7'h4C:   code = 4'd4;
         7'h24:   code = 4'd5;
         7'h20:   code = 4'd6;
         7'h0F:   code = 4'd7;
         7'h00:   code = 4'd8;
         7'h0C:   code = 4'd9;
         7'h7F:   code = 4'hF;
         default: code = 4'hE;
      endcase
      return code;
   endfunction

   logic [6:0] seg_in;
   logic [3:0] an_q;
   logic [6:0] seg_q;
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic       captured_q;
   logic       captured_d;
   logic       conflict_prev_q;
   logic [3:0] seen_q;
   logic [3:0] seen_d;
   logic [3:0] shadow [4];

   logic       valid_in;
   logic       valid_q;
   logic       conflict_q;
   logic       reload;
   logic       capture;
   logic       commit;
   logic       err_event;
   logic [1:0] slot;
   logic [3:0] code;

   assign seg_in = {CA, CB, CC, CD, CE, CF, CG};

   // The counter tracks how long the value now entering the input register has
   // been held, so it reaches N on the same edge the pattern's Nth sample lands.
   always_comb begin
      valid_in   = is_slot(AN);
      valid_q    = is_slot(an_q);
      conflict_q = !valid_q && (an_q != 4'hF);
      reload     = !valid_in || (AN != an_q) || (seg_in != seg_q) || (cnt_q == 8'd0);
      cnt_d      = 8'd0;
      if (valid_in) begin
         if (reload)
            cnt_d = 8'd1;
         else if (cnt_q == 8'hFF)
            cnt_d = 8'hFF;
         else
            cnt_d = cnt_q + 8'd1;
      end

      slot = 2'd0;
      case (an_q)
         4'b1101: slot = 2'd1;
         4'b1011: slot = 2'd2;
         4'b0111: slot = 2'd3;
         default: slot = 2'd0;
      endcase
      code      = decode(seg_q);
      capture   = valid_q && (cnt_q == STABLE_CNT) && !captured_q;
      commit    = (seen_q == 4'hF);
      err_event = (capture && (code == 4'hE)) || (conflict_q && !conflict_prev_q);

      captured_d = captured_q;
      if (reload)
         captured_d = 1'b0;
      else if (capture)
         captured_d = 1'b1;

      // A capture on the commit edge already belongs to the next frame.
      seen_d = commit ? 4'h0 : seen_q;
      if (capture)
         seen_d[slot] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q            <= 4'hF;
         seg_q           <= 7'h7F;
         cnt_q           <= 8'd0;
         captured_q      <= 1'b0;
         conflict_prev_q <= 1'b0;
         seen_q          <= 4'h0;
         for (int i = 0; i < 4; i++)
            shadow[i] <= 4'hF;
      end else begin
         an_q            <= AN;
         seg_q           <= seg_in;
         cnt_q           <= cnt_d;
         captured_q      <= captured_d;
         conflict_prev_q <= conflict_q;
         seen_q          <= seen_d;
         if (capture)
            shadow[slot] <= code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         D0         <= 4'hF;
         D1         <= 4'hF;
         D2         <= 4'hF;
         D3         <= 4'hF;
         FRAME_DONE <= 1'b0;
      end else begin
         FRAME_DONE <= commit;
         if (commit) begin
            D0 <= shadow[0];
            D1 <= shadow[1];
            D2 <= shadow[2];
            D3 <= shadow[3];
         end
      end
   end

   // A clear coinciding with a new error leaves exactly that one error recorded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ERR     <= 1'b0;
         ERR_CNT <= 8'd0;
      end else if (CLR_ERR) begin
         ERR     <= err_event;
         ERR_CNT <= err_event ? 8'd1 : 8'd0;
      end else if (err_event) begin
         ERR <= 1'b1;
         if (ERR_CNT != 8'hFF)
            ERR_CNT <= ERR_CNT + 8'd1;
      end
   end

endmodule

// File: tb/tb_seven_seg_monitor.sv
// Directed bench for seven_seg_monitor: expected frames are queued as the scan
// is driven and compared whenever the monitor reports a completed frame.
module tb_seven_seg_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] an;
   logic [6:0] seg;
   logic       clr_err;
   logic [3:0] d0, d1, d2, d3;
   logic       frame_done;
   logic       err;
   logic [7:0] err_cnt;

   int checks = 0;
   int errors = 0;
   int frames_seen = 0;
   logic prev_fd = 1'b0;
   logic [15:0] exp_q [$];

   seven_seg_monitor #(.STABLE_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .AN         (an),
      .CA         (seg[6]),
      .CB         (seg[5]),
      .CC         (seg[4]),
      .CD         (seg[3]),
      .CE         (seg[2]),
      .CF         (seg[1]),
      .CG         (seg[0]),
      .CLR_ERR    (clr_err),
      .D0         (d0),
      .D1         (d1),
      .D2         (d2),
      .D3         (d3),
      .FRAME_DONE (frame_done),
      .ERR        (err),
      .ERR_CNT    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Called on a falling edge; holds the pattern for the given number of cycles.
   task automatic apply_stimulus(input logic [3:0] an_v, input logic [6:0] seg_v, input int cycles);
      an  = an_v;
      seg = seg_v;
      repeat (cycles) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n && frame_done) begin
         frames_seen++;
         check_output("fd_back_to_back", {15'd0, prev_fd}, 16'h0);
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("[TB] FAIL unexpected_frame observed %h expected none", {d3, d2, d1, d0});
         end
         if (exp_q.size() != 0)
            check_output("frame_digits", {d3, d2, d1, d0}, exp_q.pop_front());
      end
      prev_fd = frame_done;
   end

   initial begin
      rst_n   = 1'b0;
      an      = 4'hF;
      seg     = 7'h7F;
      clr_err = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_digits", {d3, d2, d1, d0}, 16'hFFFF);
      check_output("reset_fd", {15'd0, frame_done}, 16'h0);
      check_output("reset_err", {15'd0, err}, 16'h0);
      check_output("reset_err_cnt", {8'd0, err_cnt}, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Normal frame: digits 3,9,0,2
      exp_q.push_back(16'h2093);
      apply_stimulus(4'b1110, 7'h06, 8);
      apply_stimulus(4'b1101, 7'h0C, 8);
      apply_stimulus(4'b1011, 7'h01, 8);
      apply_stimulus(4'b0111, 7'h12, 8);
      apply_stimulus(4'hF, 7'h7F, 4);
      check_output("normal_frames", 16'(frames_seen), 16'd1);
      check_output("normal_digits", {d3, d2, d1, d0}, 16'h2093);
      check_output("normal_err", {15'd0, err}, 16'h0);
      check_output("normal_err_cnt", {8'd0, err_cnt}, 16'h0);

      // Short dwell on digit 2 never captures; a 4-cycle re-hold completes the frame
      exp_q.push_back(16'h1845);
      apply_stimulus(4'b1110, 7'h24, 8);
      apply_stimulus(4'b1101, 7'h4C, 8);
      apply_stimulus(4'b1011, 7'h0F, 3);
      apply_stimulus(4'b0111, 7'h4F, 8);
      apply_stimulus(4'hF, 7'h7F, 4);
      check_output("short_dwell_frames", 16'(frames_seen), 16'd1);
      apply_stimulus(4'b1011, 7'h00, 4);
      an  = 4'hF;
      seg = 7'h7F;
      @(negedge clk);
      check_output("rehold_fd_e5", {15'd0, frame_done}, 16'h0);
      @(negedge clk);
      check_output("rehold_fd_e6", {15'd0, frame_done}, 16'h1);
      repeat (3) @(negedge clk);
      check_output("rehold_frames", 16'(frames_seen), 16'd2);

      // Blank, illegal and then a multi-cycle conflict
      exp_q.push_back(16'h96EF);
      apply_stimulus(4'b1110, 7'h7F, 8);
      apply_stimulus(4'b1101, 7'h55, 8);
      apply_stimulus(4'b1011, 7'h20, 8);
      apply_stimulus(4'b0111, 7'h0C, 8);
      apply_stimulus(4'hF, 7'h7F, 4);
      check_output("illegal_frames", 16'(frames_seen), 16'd3);
      check_output("illegal_err", {15'd0, err}, 16'h1);
      check_output("illegal_err_cnt", {8'd0, err_cnt}, 16'd1);
      apply_stimulus(4'b1100, 7'h7F, 5);
      apply_stimulus(4'hF, 7'h7F, 3);
      check_output("conflict_err_cnt", {8'd0, err_cnt}, 16'd2);

      // Five separate conflict runs bring the count to 7
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(4'b1001, 7'h7F, 1);
         apply_stimulus(4'hF, 7'h7F, 1);
      end
      apply_stimulus(4'hF, 7'h7F, 2);
      check_output("conflict_runs_err_cnt", {8'd0, err_cnt}, 16'd7);

      // Clear coincident with an illegal capture at E5
      apply_stimulus(4'b1110, 7'h55, 4);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check_output("clr_coincident_err", {15'd0, err}, 16'h1);
      check_output("clr_coincident_err_cnt", {8'd0, err_cnt}, 16'd1);
      repeat (3) @(negedge clk);

      // Three digits captured, then reset mid-frame
      apply_stimulus(4'b1101, 7'h4F, 8);
      apply_stimulus(4'b1011, 7'h12, 8);
      apply_stimulus(4'b0111, 7'h4C, 2);
      #3 rst_n = 1'b0;
      #1;
      check_output("async_reset_digits", {d3, d2, d1, d0}, 16'hFFFF);
      check_output("async_reset_fd", {15'd0, frame_done}, 16'h0);
      check_output("async_reset_err", {15'd0, err}, 16'h0);
      check_output("async_reset_err_cnt", {8'd0, err_cnt}, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(4'b0111, 7'h4C, 8);
      apply_stimulus(4'hF, 7'h7F, 4);
      check_output("post_reset_partial_frames", 16'(frames_seen), 16'd3);
      exp_q.push_back(16'h4321);
      apply_stimulus(4'b1110, 7'h4F, 8);
      apply_stimulus(4'b1101, 7'h12, 8);
      apply_stimulus(4'b1011, 7'h06, 8);
      apply_stimulus(4'hF, 7'h7F, 4);
      check_output("post_reset_frames", 16'(frames_seen), 16'd4);
      check_output("pending_frames", 16'(exp_q.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
